dp_control_unit: RTL and testbench
==================================

// Module: dp_control_unit
// PURPOSE
//  Multi-cycle controller directly downstream of fetch_instruction: consumes IR/W_IR_valid,
//  drives fetch handshake (write_ir/write_pc), evaluates ARM cond field against NZCV, decodes
//  data-processing instructions into register-file, barrel-shifter and ALU controls.
//  Sits between fetch_instruction and the registers/barrelshifter32/ALU datapath in Board.
// PARAMETERS
//  FETCH_TIMEOUT  16  max cycles in S_WAIT for W_IR_valid before fetch_err set
//  CNT_W          16  width of retired/skipped instruction counters
// PORTS
//  clk          in   1      system clock, all state on posedge
//  rst          in   1      asynchronous, active-low reset
//  IR           in   32     instruction from fetch_instruction
//  W_IR_valid   in   1      IR valid flag from fetch_instruction
//  NZCV         in   4      current flags {N,Z,C,V}
//  write_ir     out  1      1-cycle pulse: fetch stage latches new IR
//  write_pc     out  1      1-cycle pulse (with write_ir): PC <= PC+4
//  r_addr_a     out  4      Rn (IR[19:16])
//  r_addr_b     out  4      Rm (IR[3:0])
//  r_addr_c     out  4      Rs (IR[11:8])
//  w_addr       out  4      Rd (IR[15:12])
//  write_reg    out  1      register-file write enable (S_WB only)
//  write_nzcv   out  1      flag-register update enable (S_WB only)
//  ALU_OP       out  4      IR[24:21]
//  SHIFT_OP     out  3      shifter op, cpu_pkg encoding
//  Shift_Num    out  8      shift amount when num_sel=0
//  imm_data     out  32     {24'b0, IR[7:0]} for immediate operand
//  b_sel        out  1      0: shifter data = Rm, 1: shifter data = imm_data
//  num_sel      out  1      0: amount = Shift_Num, 1: amount = r_data_c[7:0]
//  busy         out  1      high in every state except S_IDLE
//  undef        out  1      sticky: non-data-processing instruction seen
//  fetch_err    out  1      sticky: S_WAIT timeout
//  retired_cnt  out  CNT_W  executed instructions (wraps at 2^CNT_W)
//  skipped_cnt  out  CNT_W  cond-failed instructions (wraps)
// BEHAVIOUR
//  - rst=0 (any time, incl. mid-instruction): state=S_IDLE; all outputs 0, counters 0, stickies 0.
//  - FSM: S_IDLE -> S_FETCH (1st edge after release) -> S_WAIT -> S_DECODE -> S_EXEC -> S_WB -> S_FETCH.
//  - S_FETCH: write_ir=write_pc=1 for exactly one cycle; always -> S_WAIT.
//  - S_WAIT: stay until W_IR_valid=1 (then latch IR into ir_q, -> S_DECODE); after FETCH_TIMEOUT
//    cycles without valid: set fetch_err, -> S_FETCH (retry).
//  - S_DECODE: cond=ir_q[31:28] vs NZCV: EQ..LE per ARM, AL=1110 true, 1111 false.
//    cond false: skipped_cnt++, -> S_FETCH. cond true & ir_q[27:26]!=00 or (ir_q[25]=0 & ir_q[7]=1 & ir_q[4]=1):
//    set undef, -> S_FETCH. else -> S_EXEC.
//  - Operand decode (valid S_EXEC..S_WB, registered from ir_q):
//    ir_q[25]=1: b_sel=1, SHIFT_OP=ROR, Shift_Num={3'b0,ir_q[11:8],1'b0}, num_sel=0.
//    ir_q[25]=0,ir_q[4]=0: b_sel=0, type=ir_q[6:5], Shift_Num={3'b0,ir_q[11:7]}, num_sel=0;
//      ROR with amount 0 -> RRX; LSR/ASR with amount 0 -> Shift_Num=32.
//    ir_q[25]=0,ir_q[4]=1: b_sel=0, type=ir_q[6:5], num_sel=1.
//  - S_EXEC: addresses/controls stable, no writes; -> S_WB.
//  - S_WB: write_reg=1 unless ALU_OP in 1000..1011 (TST/TEQ/CMP/CMN); write_nzcv=ir_q[20];
//    retired_cnt++; -> S_FETCH. Controls hold until next S_DECODE.
//  - Latency: 5 cycles per executed instr when W_IR_valid arrives 1 cycle after write_ir;
//    3 cycles per skipped instr.
//  - NZCV sampled only in S_DECODE; changes elsewhere ignored.
// STRUCTURE
//  - cpu_pkg: state encoding, SHIFT_LSL=000 LSR=010 ASR=100 ROR=110 RRX=111, cond codes,
//    ALU_OP compare range constants.
//  - Sub-module cond_check (comb: cond[3:0], NZCV -> pass); FSM/decode stay in this file.
// TESTING
//  - Reset release, W_IR_valid 1 cycle after write_ir -> write_ir/write_pc pulse once, busy=1, all others 0.
//  - IR=E2821005, NZCV=0 -> r_addr_a=2, w_addr=1, ALU_OP=0100, b_sel=1, imm_data=5, Shift_Num=0,
//    write_reg=1 in S_WB, write_nzcv=0, retired_cnt=1.
//  - IR=E1510002 (CMP r1,r2) -> write_reg=0, write_nzcv=1, ALU_OP=1010.
//  - IR=02821005 (ADDEQ), NZCV=0000 -> no write_reg, skipped_cnt=1, next write_ir 3 cycles after prior.
//  - IR=E0810312 -> r_addr_c=3, num_sel=1, SHIFT_OP=LSL; IR=EA000000 -> undef=1, no writes.
//  - W_IR_valid held 0 for 16 cycles -> fetch_err=1, re-fetch; rst=0 during S_EXEC -> all outputs 0 async.

Source files
------------

// File: rtl/dp_control_unit_pkg.sv
// Shared types and encodings for the data-processing control unit:
// FSM states, shifter op codes, ARM condition codes and compare-class ALU ops.
package dp_control_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [2:0] SHIFT_LSL = 3'b000;
  localparam logic [2:0] SHIFT_LSR = 3'b010;
  localparam logic [2:0] SHIFT_ASR = 3'b100;
  localparam logic [2:0] SHIFT_ROR = 3'b110;
  localparam logic [2:0] SHIFT_RRX = 3'b111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // TST/TEQ/CMP/CMN only update flags, never the register file
  localparam logic [3:0] ALU_CMP_LO = 4'b1000;
  localparam logic [3:0] ALU_CMP_HI = 4'b1011;

  function automatic logic [2:0] shift_type_op(input logic [1:0] shift_type);
    case (shift_type)
      2'b00:   return SHIFT_LSL;
      2'b01:   return SHIFT_LSR;
      2'b10:   return SHIFT_ASR;
      default: return SHIFT_ROR;
    endcase
  endfunction

endpackage

// File: rtl/dp_control_unit_cond_check.sv
// ARM condition-field evaluator: combinational cond[3:0] x {N,Z,C,V} -> pass.
module dp_control_unit_cond_check
  import dp_control_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_control_unit.sv
// Multi-cycle controller between fetch_instruction and the register/shifter/ALU
// datapath: fetch handshake, condition check, data-processing decode, counters.
module dp_control_unit
  import dp_control_unit_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IR,
  input  logic             W_IR_valid,
  input  logic [3:0]       NZCV,
  output logic             write_ir,
  output logic             write_pc,
  output logic [3:0]       r_addr_a,
  output logic [3:0]       r_addr_b,
  output logic [3:0]       r_addr_c,
  output logic [3:0]       w_addr,
  output logic             write_reg,
  output logic             write_nzcv,
  output logic [3:0]       ALU_OP,
  output logic [2:0]       SHIFT_OP,
  output logic [7:0]       Shift_Num,
  output logic [31:0]      imm_data,
  output logic             b_sel,
  output logic             num_sel,
  output logic             busy,
  output logic             undef,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] skipped_cnt
);

  localparam int              WAIT_W    = $clog2(FETCH_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

  state_t            state, state_next;
  logic [31:0]       ir_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              s_q;
  logic              cond_pass;
  logic              is_undef;
  logic              is_cmp;
  logic [2:0]        shift_op_d;
  logic [7:0]        shift_num_d;
  logic              b_sel_d;
  logic              num_sel_d;

  dp_control_unit_cond_check u_cond (
    .cond (ir_q[31:28]),
    .nzcv (NZCV),
    .pass (cond_pass)
  );

  // Anything outside class 00, or a register-shift form with bit7 set (multiply/extra load-store space)
  assign is_undef = (ir_q[27:26] != 2'b00) || (!ir_q[25] && ir_q[7] && ir_q[4]);
  assign is_cmp   = (ALU_OP >= ALU_CMP_LO) && (ALU_OP <= ALU_CMP_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    write_ir   = 1'b0;
    write_pc   = 1'b0;
    write_reg  = 1'b0;
    write_nzcv = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy       = 1'b0;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        write_ir   = 1'b1;
        write_pc   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (W_IR_valid)                 state_next = S_DECODE;
        else if (wait_cnt == WAIT_LAST) state_next = S_FETCH;
      end
      S_DECODE: begin
        if (!cond_pass || is_undef) state_next = S_FETCH;
        else                        state_next = S_EXEC;
      end
      S_EXEC: state_next = S_WB;
      S_WB: begin
        write_reg  = !is_cmp;
        write_nzcv = s_q;
        state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    shift_op_d  = SHIFT_LSL;
    shift_num_d = 8'd0;
    b_sel_d     = 1'b0;
    num_sel_d   = 1'b0;
    if (ir_q[25]) begin
      b_sel_d     = 1'b1;
      shift_op_d  = SHIFT_ROR;
      shift_num_d = {3'b000, ir_q[11:8], 1'b0};
    end else if (ir_q[4]) begin
      shift_op_d = shift_type_op(ir_q[6:5]);
      num_sel_d  = 1'b1;
    end else begin
      shift_op_d  = shift_type_op(ir_q[6:5]);
      shift_num_d = {3'b000, ir_q[11:7]};
      // An encoded amount of 0 means RRX for ROR and a full 32-bit shift for LSR/ASR
      if (ir_q[11:7] == 5'd0) begin
        if (shift_op_d == SHIFT_ROR)
          shift_op_d = SHIFT_RRX;
        else if (shift_op_d == SHIFT_LSR || shift_op_d == SHIFT_ASR)
          shift_num_d = 8'd32;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q        <= '0;
      wait_cnt    <= '0;
      s_q         <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_addr_c    <= '0;
      w_addr      <= '0;
      ALU_OP      <= '0;
      SHIFT_OP    <= '0;
      Shift_Num   <= '0;
      imm_data    <= '0;
      b_sel       <= 1'b0;
      num_sel     <= 1'b0;
      undef       <= 1'b0;
      fetch_err   <= 1'b0;
      retired_cnt <= '0;
      skipped_cnt <= '0;
    end else begin
      case (state)
        S_FETCH: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (W_IR_valid)                 ir_q      <= IR;
          else if (wait_cnt == WAIT_LAST) fetch_err <= 1'b1;
        end
        S_DECODE: begin
          if (!cond_pass) begin
            skipped_cnt <= skipped_cnt + CNT_W'(1);
          end else if (is_undef) begin
            undef <= 1'b1;
          end else begin
            r_addr_a  <= ir_q[19:16];
            r_addr_b  <= ir_q[3:0];
            r_addr_c  <= ir_q[11:8];
            w_addr    <= ir_q[15:12];
            ALU_OP    <= ir_q[24:21];
            s_q       <= ir_q[20];
            imm_data  <= {24'd0, ir_q[7:0]};
            SHIFT_OP  <= shift_op_d;
            Shift_Num <= shift_num_d;
            b_sel     <= b_sel_d;
            num_sel   <= num_sel_d;
          end
        end
        S_WB: retired_cnt <= retired_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_control_unit.sv
// Randomized self-checking bench for dp_control_unit: a transaction-level model
// predicts per-cycle outputs, and a negedge process compares them every cycle.
module tb_dp_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR;
  logic        W_IR_valid;
  logic [3:0]  NZCV;
  logic        write_ir, write_pc, write_reg, write_nzcv;
  logic [3:0]  r_addr_a, r_addr_b, r_addr_c, w_addr, ALU_OP;
  logic [2:0]  SHIFT_OP;
  logic [7:0]  Shift_Num;
  logic [31:0] imm_data;
  logic        b_sel, num_sel, busy, undef, fetch_err;
  logic [15:0] retired_cnt, skipped_cnt;

  dp_control_unit #(.FETCH_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .IR(IR), .W_IR_valid(W_IR_valid), .NZCV(NZCV),
    .write_ir(write_ir), .write_pc(write_pc),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_addr_c(r_addr_c), .w_addr(w_addr),
    .write_reg(write_reg), .write_nzcv(write_nzcv), .ALU_OP(ALU_OP),
    .SHIFT_OP(SHIFT_OP), .Shift_Num(Shift_Num), .imm_data(imm_data),
    .b_sel(b_sel), .num_sel(num_sel), .busy(busy), .undef(undef),
    .fetch_err(fetch_err), .retired_cnt(retired_cnt), .skipped_cnt(skipped_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // transaction-level model state
  logic [15:0] mdl_ret, mdl_skip;
  bit          mdl_undef, mdl_ferr, mdl_fresh;

  // expectations for the current cycle
  bit          chk_en = 1'b0;
  bit          e_wir, e_busy, e_wreg, e_wnzcv, e_undef, e_ferr;
  logic [15:0] e_ret, e_skip;
  int          e_ctrl;  // 0: don't care, 1: decoded values, 2: all zero
  logic [3:0]  e_ra, e_rb, e_rc, e_rd, e_alu;
  logic [2:0]  e_sop;
  logic [7:0]  e_snum;
  logic [31:0] e_imm;
  bit          e_bsel, e_nsel;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("write_ir",    32'(write_ir),    32'(e_wir));
      cmp("write_pc",    32'(write_pc),    32'(e_wir));
      cmp("busy",        32'(busy),        32'(e_busy));
      cmp("write_reg",   32'(write_reg),   32'(e_wreg));
      cmp("write_nzcv",  32'(write_nzcv),  32'(e_wnzcv));
      cmp("undef",       32'(undef),       32'(e_undef));
      cmp("fetch_err",   32'(fetch_err),   32'(e_ferr));
      cmp("retired_cnt", 32'(retired_cnt), 32'(e_ret));
      cmp("skipped_cnt", 32'(skipped_cnt), 32'(e_skip));
      if (e_ctrl == 1) begin
        cmp("r_addr_a", 32'(r_addr_a), 32'(e_ra));
        cmp("r_addr_b", 32'(r_addr_b), 32'(e_rb));
        cmp("r_addr_c", 32'(r_addr_c), 32'(e_rc));
        cmp("w_addr",   32'(w_addr),   32'(e_rd));
        cmp("ALU_OP",   32'(ALU_OP),   32'(e_alu));
        cmp("SHIFT_OP", 32'(SHIFT_OP), 32'(e_sop));
        cmp("imm_data", imm_data,      e_imm);
        cmp("b_sel",    32'(b_sel),    32'(e_bsel));
        cmp("num_sel",  32'(num_sel),  32'(e_nsel));
        if (!e_nsel) cmp("Shift_Num", 32'(Shift_Num), 32'(e_snum));
      end else if (e_ctrl == 2) begin
        cmp("ctrl_zero", {r_addr_a, r_addr_b, r_addr_c, w_addr, ALU_OP, SHIFT_OP, b_sel, num_sel, Shift_Num[5:0]}, 32'd0);
        cmp("ctrl_zero_hi", {Shift_Num[7:6], imm_data[29:0]}, 32'd0);
        cmp("imm_zero_top", 32'(imm_data[31:30]), 32'd0);
      end
    end
  end

  // ARM semantics: odd codes invert the even code's test; 111x is always / never
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic model_ctrl(input logic [31:0] ir);
    int kind, amt;
    e_ctrl = 1;
    e_ra = ir[19:16]; e_rb = ir[3:0]; e_rc = ir[11:8]; e_rd = ir[15:12];
    e_alu = ir[24:21];
    e_imm = 32'(ir[7:0]);
    kind = int'(ir[6:5]);
    amt  = int'(ir[11:7]);
    e_bsel = ir[25];
    e_nsel = !ir[25] && ir[4];
    e_snum = 8'd0;
    if (ir[25]) begin
      e_sop  = 3'd6;
      e_snum = 8'(2 * int'(ir[11:8]));
    end else begin
      e_sop = 3'(2 * kind);
      if (!ir[4]) begin
        if (amt == 0 && kind == 3)      e_sop  = 3'd7;
        else if (amt == 0 && kind != 0) e_snum = 8'd32;
        else                            e_snum = 8'(amt);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_base();
    chk_en  = 1'b1;
    e_wir   = 1'b0; e_busy = 1'b1; e_wreg = 1'b0; e_wnzcv = 1'b0;
    e_undef = mdl_undef; e_ferr = mdl_ferr;
    e_ret   = mdl_ret;   e_skip = mdl_skip;
    e_ctrl  = mdl_fresh ? 2 : 0;
  endtask

  task automatic set_idle();
    set_base();
    e_busy = 1'b0;
  endtask

  task automatic model_reset();
    mdl_ret = '0; mdl_skip = '0; mdl_undef = 1'b0; mdl_ferr = 1'b0; mdl_fresh = 1'b1;
  endtask

  task automatic rand_in();
    W_IR_valid = 1'($urandom_range(1)); IR = $urandom; NZCV = 4'($urandom);
  endtask

  // One fetch transaction: valid arrives dly cycles after the first wait cycle
  task automatic do_instr(input logic [31:0] ir, input int dly, input logic [3:0] flags, input bit abort);
    bit pass, und;
    tick(); rand_in(); set_base(); e_wir = 1'b1;
    for (int i = 0; i < dly; i++) begin
      tick(); rand_in(); W_IR_valid = 1'b0; set_base();
    end
    tick(); rand_in(); W_IR_valid = 1'b1; IR = ir; set_base();
    tick(); rand_in(); NZCV = flags; set_base();
    pass = cond_ok(ir[31:28], flags);
    und  = (ir[27:26] != 2'b00) || (!ir[25] && ir[7] && ir[4]);
    if (!pass) begin
      mdl_skip++;
      $display("instr %08h nzcv %h dly %0d: skipped", ir, flags, dly);
      return;
    end
    if (und) begin
      mdl_undef = 1'b1;
      $display("instr %08h nzcv %h dly %0d: undefined", ir, flags, dly);
      return;
    end
    tick(); rand_in(); mdl_fresh = 1'b0; set_base(); model_ctrl(ir);
    if (abort) begin
      #1; rst = 1'b0;
      model_reset(); set_idle();
      tick(); set_idle();
      tick(); rst = 1'b1; set_idle();
      $display("instr %08h: reset asserted during execute", ir);
      return;
    end
    tick(); rand_in(); set_base(); model_ctrl(ir);
    e_wreg  = !(ir[24:21] >= 4'd8 && ir[24:21] <= 4'd11);
    e_wnzcv = ir[20];
    mdl_ret++;
    $display("instr %08h nzcv %h dly %0d: executed", ir, flags, dly);
  endtask

  task automatic do_timeout();
    tick(); rand_in(); set_base(); e_wir = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(); rand_in(); W_IR_valid = 1'b0; set_base();
    end
    mdl_ferr = 1'b1;
    $display("fetch timeout: 16 cycles without W_IR_valid");
  endtask

  initial begin
    logic [31:0] ir;
    int dly;
    rst = 1'b1; IR = '0; W_IR_valid = 1'b0; NZCV = '0;
    model_reset();
    #1 rst = 1'b0;
    tick(); set_idle();
    tick(); set_idle();
    tick(); rst = 1'b1; set_idle();

    do_instr(32'hE2821005, 0, 4'h0, 1'b0);
    @(negedge clk); #1;
    cmp("lit_add_ra",   32'(r_addr_a), 32'd2);
    cmp("lit_add_rd",   32'(w_addr),   32'd1);
    cmp("lit_add_alu",  32'(ALU_OP),   32'h4);
    cmp("lit_add_bsel", 32'(b_sel),    32'd1);
    cmp("lit_add_imm",  imm_data,      32'd5);
    cmp("lit_add_snum", 32'(Shift_Num), 32'd0);
    cmp("lit_add_wreg", 32'(write_reg), 32'd1);
    cmp("lit_add_wnzcv", 32'(write_nzcv), 32'd0);

    do_instr(32'hE1510002, 0, 4'($urandom), 1'b0);
    @(negedge clk); #1;
    cmp("lit_cmp_wreg",  32'(write_reg),  32'd0);
    cmp("lit_cmp_wnzcv", 32'(write_nzcv), 32'd1);
    cmp("lit_cmp_alu",   32'(ALU_OP),     32'hA);
    cmp("lit_cmp_ret",   32'(retired_cnt), 32'd1);

    do_instr(32'h02821005, 0, 4'h0, 1'b0);
    do_instr(32'hE0810312, 0, 4'h0, 1'b0);
    @(negedge clk); #1;
    cmp("lit_rs_rc",    32'(r_addr_c),    32'd3);
    cmp("lit_rs_nsel",  32'(num_sel),     32'd1);
    cmp("lit_rs_sop",   32'(SHIFT_OP),    32'd0);
    cmp("lit_rs_skip",  32'(skipped_cnt), 32'd1);
    cmp("lit_rs_ret",   32'(retired_cnt), 32'd2);

    do_instr(32'hEA000000, 0, 4'h0, 1'b0);
    do_timeout();
    do_instr(32'hE2821005, 15, 4'h0, 1'b0);
    @(negedge clk); #1;
    cmp("lit_undef",    32'(undef),       32'd1);
    cmp("lit_ferr",     32'(fetch_err),   32'd1);
    cmp("lit_ret3",     32'(retired_cnt), 32'd3);

    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(39) == 0) begin
        do_timeout();
      end else begin
        ir = $urandom;
        if ($urandom_range(3) != 0) ir[27:26] = 2'b00;
        if ($urandom_range(2) == 0) ir[31:28] = 4'hE;
        dly = ($urandom_range(9) == 0) ? 15 : int'($urandom_range(3));
        do_instr(ir, dly, 4'($urandom), 1'b0);
      end
    end

    do_instr(32'hE0810312, 0, 4'h0, 1'b1);
    do_instr(32'hE2821005, 1, 4'h0, 1'b0);
    @(negedge clk); #1;
    cmp("lit_post_rst_ret",   32'(retired_cnt), 32'd0);
    cmp("lit_post_rst_undef", 32'(undef),       32'd0);
    tick(); set_base(); e_wir = 1'b1;
    @(negedge clk); #1;
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
